pbuf_load_ctrl: RTL and testbench

//  Sequences DDR-to-pbuf parameter loads. Queues transfer descriptors, configures
//  and starts ddr2pbuf, issues DDR read bursts on channel 1 (update data) and

---
 rtl/pbuf_load_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_pbuf_load_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbuf_load_ctrl.sv
// DDR-to-pbuf load sequencer: queues descriptors, starts ddr2pbuf, issues ch1/ch2 read bursts.
// Optional PBUF_LOAD_PERF_EN adds busy-cycle and completed-command counters.
module pbuf_load_ctrl #(
   parameter int unsigned PE_NUM     = 32,
   parameter int unsigned DDR_AW     = 32,
   parameter int unsigned LEN_W      = 12,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_mode,
   input  logic [11:0]       cmd_trans_num,
   input  logic [3:0]        cmd_ch_num,
   input  logic [3:0]        cmd_pix_num,
   input  logic [1:0]        cmd_row_num,
   input  logic              cmd_depool,
   input  logic [PE_NUM-1:0] cmd_mask,
   input  logic [DDR_AW-1:0] cmd_addr1,
   input  logic [DDR_AW-1:0] cmd_addr2,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic              rd1_valid,
   output logic [DDR_AW-1:0] rd1_addr,
   output logic [LEN_W-1:0]  rd1_len,
   input  logic              rd1_ready,
   output logic              rd2_valid,
   output logic [DDR_AW-1:0] rd2_addr,
   output logic [LEN_W-1:0]  rd2_len,
   input  logic              rd2_ready,
   output logic              pb_start,
   input  logic              pb_done,
   output logic [11:0]       pb_conf_trans_num,
   output logic [3:0]        pb_conf_mode,
   output logic [3:0]        pb_conf_ch_num,
   output logic [3:0]        pb_conf_pix_num,
   output logic [1:0]        pb_conf_row_num,
   output logic              pb_conf_depool,
   output logic [PE_NUM-1:0] pb_conf_mask,
   output logic              busy,
   output logic              cmd_done
`ifdef PBUF_LOAD_PERF_EN
   ,
   output logic [31:0]       perf_busy_cyc,
   output logic [15:0]       perf_cmd_cnt
`endif
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef struct packed {
      logic [3:0]        mode;
      logic [11:0]       trans_num;
      logic [3:0]        ch_num;
      logic [3:0]        pix_num;
      logic [1:0]        row_num;
      logic              depool;
      logic [PE_NUM-1:0] mask;
      logic [DDR_AW-1:0] addr1;
      logic [DDR_AW-1:0] addr2;
      logic [LEN_W-1:0]  len;
   } desc_t;

   typedef enum logic [2:0] {StIdle, StLoad, StStart, StReq, StWait, StDone} state_t;

   state_t        state;
   desc_t         fifo_mem [FIFO_DEPTH];
   desc_t         head;
   desc_t         wr_desc;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   assign full      = (count == (PW + 1)'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == StLoad);
   assign head      = fifo_mem[rd_ptr];
   assign busy      = (state != StIdle) || !empty;

   always_comb begin
      wr_desc           = '0;
      wr_desc.mode      = cmd_mode;
      wr_desc.trans_num = cmd_trans_num;
      wr_desc.ch_num    = cmd_ch_num;
      wr_desc.pix_num   = cmd_pix_num;
      wr_desc.row_num   = cmd_row_num;
      wr_desc.depool    = cmd_depool;
      wr_desc.mask      = cmd_mask;
      wr_desc.addr1     = cmd_addr1;
      wr_desc.addr2     = cmd_addr2;
      wr_desc.len       = cmd_len;
   end

   // Storage needs no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= wr_desc;
   end

   // Depth is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= StIdle;
         pb_start          <= 1'b0;
         cmd_done          <= 1'b0;
         rd1_valid         <= 1'b0;
         rd2_valid         <= 1'b0;
         rd1_addr          <= '0;
         rd2_addr          <= '0;
         rd1_len           <= '0;
         rd2_len           <= '0;
         pb_conf_trans_num <= '0;
         pb_conf_mode      <= '0;
         pb_conf_ch_num    <= '0;
         pb_conf_pix_num   <= '0;
         pb_conf_row_num   <= '0;
         pb_conf_depool    <= 1'b0;
         pb_conf_mask      <= '0;
      end else begin
         pb_start <= 1'b0;
         cmd_done <= 1'b0;
         case (state)
            // A push this cycle counts as non-empty to save a cycle of latency.
            StIdle: if (!empty || push) state <= StLoad;
            StLoad: begin
               pb_conf_trans_num <= head.trans_num;
               pb_conf_mode      <= head.mode;
               pb_conf_ch_num    <= head.ch_num;
               pb_conf_pix_num   <= head.pix_num;
               pb_conf_row_num   <= head.row_num;
               pb_conf_depool    <= head.depool;
               pb_conf_mask      <= head.mask;
               rd1_addr          <= head.addr1;
               rd2_addr          <= head.addr2;
               rd1_len           <= head.len;
               rd2_len           <= head.len;
               pb_start          <= 1'b1;
               state             <= StStart;
            end
            // ddr2pbuf has seen its start pulse before any read is requested.
            StStart: begin
               rd2_valid <= 1'b1;
               rd1_valid <= (pb_conf_mode[2:1] == 2'b10);
               state     <= StReq;
            end
            StReq: begin
               if (rd1_valid && rd1_ready) rd1_valid <= 1'b0;
               if (rd2_valid && rd2_ready) rd2_valid <= 1'b0;
               if ((!rd1_valid || rd1_ready) && (!rd2_valid || rd2_ready)) state <= StWait;
            end
            // pb_done is only trusted here; earlier it may be left over from the last load.
            StWait: begin
               if (pb_done) begin
                  cmd_done <= 1'b1;
                  state    <= StDone;
               end
            end
            StDone:  state <= empty ? StIdle : StLoad;
            default: state <= StIdle;
         endcase
      end
   end

`ifdef PBUF_LOAD_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_busy_cyc <= '0;
         perf_cmd_cnt  <= '0;
      end else begin
         if ((state != StIdle) && (perf_busy_cyc != '1)) perf_busy_cyc <= perf_busy_cyc + 1'b1;
         if (cmd_done) perf_cmd_cnt <= perf_cmd_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pbuf_load_ctrl.sv
// Randomized bench for pbuf_load_ctrl against a transaction-level reference model.
// Define PBUF_LOAD_PERF_EN to also check the performance counters.
module tb_pbuf_load_ctrl;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_mode;
   logic [11:0] cmd_trans_num;
   logic [3:0]  cmd_ch_num;
   logic [3:0]  cmd_pix_num;
   logic [1:0]  cmd_row_num;
   logic        cmd_depool;
   logic [31:0] cmd_mask;
   logic [31:0] cmd_addr1;
   logic [31:0] cmd_addr2;
   logic [11:0] cmd_len;
   logic        rd1_valid;
   logic [31:0] rd1_addr;
   logic [11:0] rd1_len;
   logic        rd1_ready;
   logic        rd2_valid;
   logic [31:0] rd2_addr;
   logic [11:0] rd2_len;
   logic        rd2_ready;
   logic        pb_start;
   logic        pb_done;
   logic [11:0] pb_conf_trans_num;
   logic [3:0]  pb_conf_mode;
   logic [3:0]  pb_conf_ch_num;
   logic [3:0]  pb_conf_pix_num;
   logic [1:0]  pb_conf_row_num;
   logic        pb_conf_depool;
   logic [31:0] pb_conf_mask;
   logic        busy;
   logic        cmd_done;
`ifdef PBUF_LOAD_PERF_EN
   logic [31:0] perf_busy_cyc;
   logic [15:0] perf_cmd_cnt;
`endif

   pbuf_load_ctrl #(
      .PE_NUM    (32),
      .DDR_AW    (32),
      .LEN_W     (12),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_mode         (cmd_mode),
      .cmd_trans_num    (cmd_trans_num),
      .cmd_ch_num       (cmd_ch_num),
      .cmd_pix_num      (cmd_pix_num),
      .cmd_row_num      (cmd_row_num),
      .cmd_depool       (cmd_depool),
      .cmd_mask         (cmd_mask),
      .cmd_addr1        (cmd_addr1),
      .cmd_addr2        (cmd_addr2),
      .cmd_len          (cmd_len),
      .rd1_valid        (rd1_valid),
      .rd1_addr         (rd1_addr),
      .rd1_len          (rd1_len),
      .rd1_ready        (rd1_ready),
      .rd2_valid        (rd2_valid),
      .rd2_addr         (rd2_addr),
      .rd2_len          (rd2_len),
      .rd2_ready        (rd2_ready),
      .pb_start         (pb_start),
      .pb_done          (pb_done),
      .pb_conf_trans_num(pb_conf_trans_num),
      .pb_conf_mode     (pb_conf_mode),
      .pb_conf_ch_num   (pb_conf_ch_num),
      .pb_conf_pix_num  (pb_conf_pix_num),
      .pb_conf_row_num  (pb_conf_row_num),
      .pb_conf_depool   (pb_conf_depool),
      .pb_conf_mask     (pb_conf_mask),
      .busy             (busy),
      .cmd_done         (cmd_done)
`ifdef PBUF_LOAD_PERF_EN
      ,
      .perf_busy_cyc    (perf_busy_cyc),
      .perf_cmd_cnt     (perf_cmd_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  mode;
      logic [11:0] trans;
      logic [3:0]  ch;
      logic [3:0]  pix;
      logic [1:0]  row;
      logic        depool;
      logic [31:0] mask;
      logic [31:0] a1;
      logic [31:0] a2;
      logic [11:0] len;
   } desc_t;

   // Descriptor life cycle as seen at the ports.
   typedef enum int {PhIdle, PhLoad, PhStart, PhReq, PhWait, PhDone} phase_t;

   int     errors = 0;
   int     checks = 0;
   desc_t  pend_q[$];
   desc_t  cur;
   desc_t  conf;
   desc_t  nd;
   phase_t phase;
   logic   exp_start, exp_rd1, exp_rd2, exp_done;
   int     busy_cyc_cnt;
   int     done_cnt;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      pend_q.delete();
      phase        = PhIdle;
      cur          = '0;
      conf         = '0;
      exp_start    = 1'b0;
      exp_rd1      = 1'b0;
      exp_rd2      = 1'b0;
      exp_done     = 1'b0;
      busy_cyc_cnt = 0;
      done_cnt     = 0;
   endtask

   task automatic check_cycle();
      check("pb_start", pb_start, exp_start);
      check("rd1_valid", rd1_valid, exp_rd1);
      check("rd2_valid", rd2_valid, exp_rd2);
      check("cmd_done", cmd_done, exp_done);
      check("cmd_ready", cmd_ready, pend_q.size() < DEPTH);
      check("busy", busy, (pend_q.size() > 0) || (phase != PhIdle));
      check("pb_conf", {pb_conf_trans_num, pb_conf_mode, pb_conf_ch_num, pb_conf_pix_num,
                        pb_conf_row_num, pb_conf_depool, pb_conf_mask},
            {conf.trans, conf.mode, conf.ch, conf.pix, conf.row, conf.depool, conf.mask});
      if (exp_rd1) check("rd1_req", {rd1_addr, rd1_len}, {cur.a1, cur.len});
      if (exp_rd2) check("rd2_req", {rd2_addr, rd2_len}, {cur.a2, cur.len});
`ifdef PBUF_LOAD_PERF_EN
      check("perf_busy_cyc", perf_busy_cyc, busy_cyc_cnt);
      check("perf_cmd_cnt", perf_cmd_cnt, 16'(done_cnt));
`endif
   endtask

   // Advance the model across one clock edge using this cycle's inputs.
   task automatic model_step();
      logic   push;
      logic   upd;
      phase_t nxt;
      if (rst) begin
         model_reset();
         return;
      end
      if (phase != PhIdle) busy_cyc_cnt++;
      if (exp_done) done_cnt++;
      push      = cmd_valid && (pend_q.size() < DEPTH);
      nxt       = phase;
      exp_start = 1'b0;
      exp_done  = 1'b0;
      case (phase)
         PhIdle: if (pend_q.size() > 0 || push) nxt = PhLoad;
         PhLoad: begin
            cur       = pend_q.pop_front();
            conf      = cur;
            exp_start = 1'b1;
            nxt       = PhStart;
         end
         PhStart: begin
            upd     = (cur.mode[2:1] == 2'b10);
            exp_rd1 = upd;
            exp_rd2 = 1'b1;
            nxt     = PhReq;
         end
         PhReq: begin
            if (rd1_ready) exp_rd1 = 1'b0;
            if (rd2_ready) exp_rd2 = 1'b0;
            if (!exp_rd1 && !exp_rd2) nxt = PhWait;
         end
         PhWait: begin
            if (pb_done) begin
               exp_done = 1'b1;
               nxt      = PhDone;
            end
         end
         PhDone: nxt = (pend_q.size() > 0) ? PhLoad : PhIdle;
         default: nxt = PhIdle;
      endcase
      if (push) pend_q.push_back(nd);
      phase = nxt;
   endtask

   task automatic drive(input int p_valid, input int p_ready, input int p_done, input int p_rst);
      logic [3:0] m;
      rst = ($urandom_range(0, 999) < p_rst);
      m   = 4'($urandom);
      if ($urandom_range(0, 1) == 1) m[2:1] = 2'b10;
      nd.mode   = m;
      nd.trans  = 12'($urandom);
      nd.ch     = 4'($urandom);
      nd.pix    = 4'($urandom);
      nd.row    = 2'($urandom);
      nd.depool = 1'($urandom);
      nd.mask   = $urandom;
      nd.a1     = $urandom;
      nd.a2     = $urandom;
      nd.len    = 12'($urandom);
      cmd_valid     = ($urandom_range(0, 99) < p_valid);
      cmd_mode      = nd.mode;
      cmd_trans_num = nd.trans;
      cmd_ch_num    = nd.ch;
      cmd_pix_num   = nd.pix;
      cmd_row_num   = nd.row;
      cmd_depool    = nd.depool;
      cmd_mask      = nd.mask;
      cmd_addr1     = nd.a1;
      cmd_addr2     = nd.a2;
      cmd_len       = nd.len;
      rd1_ready     = ($urandom_range(0, 99) < p_ready);
      rd2_ready     = ($urandom_range(0, 99) < p_ready);
      pb_done       = ($urandom_range(0, 99) < p_done);
   endtask

   // Per segment: cmd_valid %, ready %, pb_done %, reset per mille.
   int seg_valid [4] = '{30, 60, 90, 50};
   int seg_ready [4] = '{100, 40, 30, 70};
   int seg_done  [4] = '{30, 100, 10, 60};
   int seg_rst   [4] = '{0, 2, 3, 5};

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      rd1_ready = 1'b0;
      rd2_ready = 1'b0;
      pb_done   = 1'b0;
      nd        = '0;
      cmd_mode = '0; cmd_trans_num = '0; cmd_ch_num = '0; cmd_pix_num = '0;
      cmd_row_num = '0; cmd_depool = 1'b0; cmd_mask = '0; cmd_addr1 = '0;
      cmd_addr2 = '0; cmd_len = '0;
      model_reset();
      repeat (2) @(posedge clk);
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            check_cycle();
            drive(seg_valid[s], seg_ready[s], seg_done[s], seg_rst[s]);
            model_step();
         end
      end
      // Drain with everything ready so the queue empties and the block goes idle.
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         check_cycle();
         drive(0, 100, 100, 0);
         model_step();
      end
      @(negedge clk);
      check_cycle();
      check("idle_at_end", busy, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
